// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code parser feeding a per-frame move code; held mask updates 1 cycle after rx_done_tick,
// move/move_valid 1 cycle after frame_tick; no backpressure, every byte and frame strobe is consumed.
module ps2_move_decoder #(
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd500000,
    parameter logic [7:0]  SC_UP          = 8'h1D,
    parameter logic [7:0]  SC_LEFT        = 8'h1C,
    parameter logic [7:0]  SC_DOWN        = 8'h1B,
    parameter logic [7:0]  SC_RIGHT       = 8'h23,
    parameter logic [7:0]  SC_ACTION      = 8'h29
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       frame_tick,
    output logic [2:0] move,
    output logic       move_valid,
    output logic [4:0] held,
    output logic       proto_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_cnt;
    logic [4:0]  r_held;
    logic [2:0]  r_move;
    logic        r_move_valid;
    logic        r_proto_err;
    logic        r_tap_pending;
    logic [2:0]  r_tap_key;
    logic [2:0]  r_last_key;

    logic        w_make;
    logic        w_break;
    logic        w_ext;
    logic        w_err;
    logic        w_timeout;
    logic [2:0]  w_code;
    logic        w_hit;
    logic [4:0]  w_bit;
    logic        w_last_held;
    logic [2:0]  w_sel;

    // Key codes double as move codes; held bit index is code-1.
    function automatic logic [2:0] key_code(input logic [7:0] b, input logic ext);
        logic [2:0] c;
        c = 3'd0;
        if (!ext) begin
            if (b == SC_UP)          c = 3'd1;
            else if (b == SC_LEFT)   c = 3'd2;
            else if (b == SC_DOWN)   c = 3'd3;
            else if (b == SC_RIGHT)  c = 3'd4;
            else if (b == SC_ACTION) c = 3'd5;
        end else begin
            if (b == 8'h75)          c = 3'd1;
            else if (b == 8'h6B)     c = 3'd2;
            else if (b == 8'h72)     c = 3'd3;
            else if (b == 8'h74)     c = 3'd4;
        end
        return c;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        w_ext       = 1'b0;
        w_err       = 1'b0;
        w_timeout   = (r_state != ST_IDLE) && (r_cnt == PREFIX_TIMEOUT - 20'd1);
        if (rx_done_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == 8'hF0)      w_state_nxt = ST_F0;
                    else if (rx_data == 8'hE0) w_state_nxt = ST_E0;
                    else                       w_make = 1'b1;
                end
                ST_E0: begin
                    if (rx_data == 8'hF0)      w_state_nxt = ST_E0F0;
                    else if (rx_data == 8'hE0) w_err = 1'b1;
                    else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_F0: begin
                    w_state_nxt = ST_IDLE;
                    if (rx_data == 8'hE0 || rx_data == 8'hF0) w_err = 1'b1;
                    else                                      w_break = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ext       = 1'b1;
                    if (rx_data == 8'hE0 || rx_data == 8'hF0) w_err = 1'b1;
                    else                                      w_break = 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    assign w_code      = key_code(rx_data, w_ext);
    assign w_hit       = (w_code != 3'd0);
    assign w_bit       = w_hit ? (5'd1 << (w_code - 3'd1)) : 5'd0;
    assign w_last_held = (r_last_key != 3'd0) && |(r_held & (5'd1 << (r_last_key - 3'd1)));

    always_comb begin
        w_sel = 3'd0;
        if (r_tap_pending)  w_sel = r_tap_key;
        else if (w_last_held) w_sel = r_last_key;
        else if (r_held[0]) w_sel = 3'd1;
        else if (r_held[2]) w_sel = 3'd3;
        else if (r_held[1]) w_sel = 3'd2;
        else if (r_held[3]) w_sel = 3'd4;
        else if (r_held[4]) w_sel = 3'd5;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 20'd0;
            r_held        <= 5'd0;
            r_move        <= 3'd0;
            r_move_valid  <= 1'b0;
            r_proto_err   <= 1'b0;
            r_tap_pending <= 1'b0;
            r_tap_key     <= 3'd0;
            r_last_key    <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_move_valid <= frame_tick;
            if (rx_done_tick || w_timeout || r_state == ST_IDLE) r_cnt <= 20'd0;
            else                                                 r_cnt <= r_cnt + 20'd1;
            if (w_err) r_proto_err <= 1'b1;
            if (frame_tick) begin
                r_move        <= w_sel;
                r_tap_pending <= 1'b0;
            end
            // A make landing on the sample edge re-arms the tap for the following frame.
            if (w_make && w_hit && !(|(r_held & w_bit))) begin
                r_held     <= r_held | w_bit;
                r_last_key <= w_code;
                if (!r_tap_pending || frame_tick) begin
                    r_tap_pending <= 1'b1;
                    r_tap_key     <= w_code;
                end
            end
            if (w_break && w_hit) begin
                r_held <= r_held & ~w_bit;
                if (r_last_key == w_code) r_last_key <= 3'd0;
            end
        end
    end

    assign move       = r_move;
    assign move_valid = r_move_valid;
    assign held       = r_held;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: inputs driven 1 time unit after each rising edge,
// outputs sampled at that same point, short prefix timeout to keep the run brief.
module tb_ps2_move_decoder;

    localparam logic [19:0] TO = 20'd16;

    logic       clk;
    logic       resetn;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       frame_tick;
    logic [2:0] move;
    logic       move_valid;
    logic [4:0] held;
    logic       proto_err;

    int errors;
    int checks;

    ps2_move_decoder #(.PREFIX_TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .frame_tick   (frame_tick),
        .move         (move),
        .move_valid   (move_valid),
        .held         (held),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        resetn       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        frame_tick   = 1'b0;
        idle(2);
        chk("rst_move", {5'd0, move}, 8'h0);
        chk("rst_valid", {7'd0, move_valid}, 8'h0);
        chk("rst_held", {3'd0, held}, 8'h00);
        chk("rst_perr", {7'd0, proto_err}, 8'h0);
        resetn = 1'b1;
        idle(1);

        // Single make of W
        send(8'h1D);
        chk("w_held", {3'd0, held}, 8'h01);
        frame();
        chk("w_move", {5'd0, move}, 8'h1);
        chk("w_valid", {7'd0, move_valid}, 8'h1);
        idle(1);
        chk("w_valid_drop", {7'd0, move_valid}, 8'h0);
        chk("w_move_hold", {5'd0, move}, 8'h1);
        send(8'hF0); send(8'h1D);
        chk("w_release", {3'd0, held}, 8'h00);
        frame();
        chk("w_release_move", {5'd0, move}, 8'h0);

        // Extended arrow right, make then break
        send(8'hE0); send(8'h74);
        frame();
        chk("ar_move", {5'd0, move}, 8'h4);
        chk("ar_held", {3'd0, held}, 8'h08);
        send(8'hE0); send(8'hF0); send(8'h74);
        frame();
        chk("ar_brk_move", {5'd0, move}, 8'h0);
        chk("ar_brk_held", {3'd0, held}, 8'h00);

        // Tap of A between frames
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("tap_held", {3'd0, held}, 8'h00);
        frame();
        chk("tap_move", {5'd0, move}, 8'h2);
        frame();
        chk("tap_move2", {5'd0, move}, 8'h0);

        // Two keys: tap, then last_key, then fixed-priority fallback
        send(8'h1D); send(8'h23);
        frame();
        chk("two_tap", {5'd0, move}, 8'h1);
        frame();
        chk("two_last", {5'd0, move}, 8'h4);
        send(8'hF0); send(8'h23);
        frame();
        chk("two_fallback", {5'd0, move}, 8'h1);
        send(8'h1D); send(8'h1D); send(8'h1D);
        chk("repeat_held", {3'd0, held}, 8'h01);
        frame();
        chk("repeat_move", {5'd0, move}, 8'h1);
        send(8'hF0); send(8'h1D);
        chk("no_perr_yet", {7'd0, proto_err}, 8'h0);

        // E0 1D is not an alias of W
        send(8'hE0); send(8'h1D);
        chk("ext_mismatch_held", {3'd0, held}, 8'h00);
        frame();
        chk("ext_mismatch_move", {5'd0, move}, 8'h0);

        // Space make on the same edge as a frame sample
        rx_done_tick = 1'b1;
        rx_data      = 8'h29;
        frame_tick   = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        frame_tick   = 1'b0;
        chk("sim_move", {5'd0, move}, 8'h0);
        chk("sim_valid", {7'd0, move_valid}, 8'h1);
        chk("sim_held", {3'd0, held}, 8'h10);
        frame();
        chk("sim_next_move", {5'd0, move}, 8'h5);
        send(8'hF0); send(8'h29);
        chk("sim_release", {3'd0, held}, 8'h00);

        // Prefix timeout
        send(8'hE0);
        idle(int'(TO) - 2);
        chk("to_before", {7'd0, proto_err}, 8'h0);
        idle(3);
        chk("to_after", {7'd0, proto_err}, 8'h1);
        send(8'h1D);
        chk("to_plain_make", {3'd0, held}, 8'h01);
        frame();
        chk("to_move", {5'd0, move}, 8'h1);

        // Reset with a key held and a prefix pending
        send(8'hE0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_move", {5'd0, move}, 8'h0);
        chk("mid_rst_held", {3'd0, held}, 8'h00);
        chk("mid_rst_perr", {7'd0, proto_err}, 8'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        send(8'h74);
        chk("mid_rst_fsm_idle", {3'd0, held}, 8'h00);

        // Illegal prefix sequence
        send(8'hF0); send(8'hF0);
        chk("illegal_perr", {7'd0, proto_err}, 8'h1);
        send(8'h1D);
        chk("illegal_recover", {3'd0, held}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
